data_sram_resp: RTL

- Responder (slave) end of the single-cycle SRAM-style data interface driven by the CPU core: en / wen / addr / wdata in, rdata returned one cycle later.
- Contains a word-organised byte-writable RAM plus a small memory-mapped config-register window (LED, NUM, free-running TIMER, memory-write counter).
- Sits outside the CPU top in the SoC shell and serves data_sram_* directly.
- No back-pressure: every enabled request is served in exactly one cycle.

---
 rtl/data_sram_resp_if.sv | 24 ++
 rtl/data_sram_resp.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/data_sram_resp_if.sv
// Single-cycle SRAM-style data bus between the CPU core (master) and its responder (slave).
interface data_sram_resp_if;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output sram_en,
        output sram_wen,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en,
        input  sram_wen,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: byte-writable word RAM plus LED/NUM/TIMER/WR_CNT config window, 1-cycle read latency.
// Define DATA_SRAM_RESP_TIMER_EN to build the free-running TIMER at offset 0xE000.
module data_sram_resp #(
    parameter int unsigned MEM_AW    = 12,
    parameter logic [31:0] CONF_BASE = 32'hbfaf_0000,
    parameter logic [31:0] CONF_MASK = 32'hffff_0000
) (
    input  logic                   clk,
    input  logic                   resetn,
    data_sram_resp_if.slave        bus,
    output logic [15:0]            led,
    output logic [31:0]            num_data
);

    localparam int unsigned DEPTH     = 1 << MEM_AW;
    localparam int unsigned NLANES    = 4;
    localparam logic [15:0] OFF_LED   = 16'h0000;
    localparam logic [15:0] OFF_NUM   = 16'h0004;
    localparam logic [15:0] OFF_TIMER = 16'he000;
    localparam logic [15:0] OFF_WRCNT = 16'hf000;

    logic [31:0]       mem_q [DEPTH];

    logic              conf_hit_c;
    logic [15:0]       offset_c;
    logic [MEM_AW-1:0] ram_idx_c;
    logic              ram_wr_c;
    logic              conf_wr_c;
    logic [31:0]       ram_rd_c;
    logic [31:0]       conf_rd_c;
    logic [31:0]       timer_rd_c;

    logic [31:0]       rdata_q, rdata_d;
    logic [15:0]       led_q,   led_d;
    logic [31:0]       num_q,   num_d;
    logic [31:0]       wrcnt_q, wrcnt_d;

    // Address decode
    always_comb begin
        conf_hit_c = ((bus.sram_addr & CONF_MASK) == CONF_BASE);
        offset_c   = bus.sram_addr[15:0];
        ram_idx_c  = bus.sram_addr[MEM_AW+1:2];
        ram_wr_c   = bus.sram_en && !conf_hit_c && (bus.sram_wen != 4'h0);
        conf_wr_c  = bus.sram_en &&  conf_hit_c;
        ram_rd_c   = mem_q[ram_idx_c];
    end

    // RAM array: never reset, contents survive resetn
    always_ff @(posedge clk) begin
        if (ram_wr_c) begin
            for (int i = 0; i < NLANES; i++) begin
                if (bus.sram_wen[i]) begin
                    mem_q[ram_idx_c][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef DATA_SRAM_RESP_TIMER_EN
    logic [31:0] timer_q, timer_d;

    // A full-word write overrides that cycle's increment
    always_comb begin
        timer_d    = timer_q + 32'd1;
        timer_rd_c = timer_q;
        if (conf_wr_c && (offset_c == OFF_TIMER) && (bus.sram_wen == 4'hf)) begin
            timer_d = bus.sram_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    always_comb begin
        timer_rd_c = '0;
    end
`endif

    // Config read mux
    always_comb begin
        conf_rd_c = '0;
        case (offset_c)
            OFF_LED:   conf_rd_c = {16'h0, led_q};
            OFF_NUM:   conf_rd_c = num_q;
            OFF_TIMER: conf_rd_c = timer_rd_c;
            OFF_WRCNT: conf_rd_c = wrcnt_q;
            default:   conf_rd_c = '0;
        endcase
    end

    // Next-state for read data and config registers
    always_comb begin
        rdata_d = rdata_q;
        led_d   = led_q;
        num_d   = num_q;
        wrcnt_d = wrcnt_q;

        if (bus.sram_en) begin
            rdata_d = conf_hit_c ? conf_rd_c : ram_rd_c;
        end

        if (conf_wr_c && (offset_c == OFF_LED)) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.sram_wen[i]) begin
                    led_d[8*i +: 8] = bus.sram_wdata[8*i +: 8];
                end
            end
        end

        if (conf_wr_c && (offset_c == OFF_NUM)) begin
            for (int i = 0; i < NLANES; i++) begin
                if (bus.sram_wen[i]) begin
                    num_d[8*i +: 8] = bus.sram_wdata[8*i +: 8];
                end
            end
        end

        // Saturating count of RAM-bound writes
        if (ram_wr_c && (wrcnt_q != 32'hffff_ffff)) begin
            wrcnt_d = wrcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
            led_q   <= '0;
            num_q   <= '0;
            wrcnt_q <= '0;
        end else begin
            rdata_q <= rdata_d;
            led_q   <= led_d;
            num_q   <= num_d;
            wrcnt_q <= wrcnt_d;
        end
    end

    assign bus.sram_rdata = rdata_q;
    assign led            = led_q;
    assign num_data       = num_q;

endmodule
